// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
package hazard_pkg;

    localparam int SLOT_AW = 5;
    localparam int FWD_RF  = 0;

    typedef struct packed {
        logic               valid;
        logic [SLOT_AW-1:0] rd;
        logic               reg_write;
        logic               is_load;
    } slot_t;

    function automatic int fwd_w(input int mem_stages);
        return $clog2(mem_stages + 2);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] o_count
);

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller: tracks in-flight instructions from E to W and
// produces load-use stalls, redirect flushes and E-stage forwarding selects.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MEM_STAGES = 1,
    parameter int FWD_W      = fwd_w(MEM_STAGES),
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold_i,
    input  logic                 dec_valid_i,
    input  logic [REG_AW-1:0]    dec_rs1_i,
    input  logic [REG_AW-1:0]    dec_rs2_i,
    input  logic                 dec_use_rs1_i,
    input  logic                 dec_use_rs2_i,
    input  logic [REG_AW-1:0]    dec_rd_i,
    input  logic                 dec_reg_write_i,
    input  logic                 dec_is_load_i,
    input  logic                 redirect_e_i,
    output logic                 stall_fd_o,
    output logic                 flush_d_o,
    output logic                 flush_e_o,
    output logic [FWD_W-1:0]     fwd_rs1_e_o,
    output logic [FWD_W-1:0]     fwd_rs2_e_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    localparam int W_SLOT = MEM_STAGES + 1;

    // Slot 0 is E, slots 1..MEM_STAGES are the memory stages, W_SLOT is writeback.
    slot_t [W_SLOT:0]  r_slot;
    logic [REG_AW-1:0] r_e_rs1;
    logic [REG_AW-1:0] r_e_rs2;
    logic              r_e_use_rs1;
    logic              r_e_use_rs2;

    logic [FWD_W-1:0]     w_fwd_rs1;
    logic [FWD_W-1:0]     w_fwd_rs2;
    logic                 w_lu_rs1;
    logic                 w_lu_rs2;
    logic                 w_load_use;
    logic                 w_issue;
    logic                 w_stall_inc;
    logic                 w_flush_inc;
    logic [CNT_WIDTH-1:0] w_stall_cnt;
    logic [CNT_WIDTH-1:0] w_flush_cnt;

    function automatic logic slot_match(input slot_t s, input logic [REG_AW-1:0] src,
                                        input logic use_src);
        return s.valid && s.reg_write && use_src && (src != '0) && (s.rd == SLOT_AW'(src));
    endfunction

    // Scanning oldest to youngest lets the youngest match overwrite the result.
    always_comb begin
        w_fwd_rs1 = FWD_W'(FWD_RF);
        w_fwd_rs2 = FWD_W'(FWD_RF);
        for (int k = W_SLOT; k >= 1; k--) begin
            if (slot_match(r_slot[k], r_e_rs1, r_e_use_rs1)) w_fwd_rs1 = FWD_W'(k);
            if (slot_match(r_slot[k], r_e_rs2, r_e_use_rs2)) w_fwd_rs2 = FWD_W'(k);
        end
    end

    // A load at or beyond the last memory stage never stalls, so scanning through W is harmless.
    always_comb begin
        w_lu_rs1 = 1'b0;
        w_lu_rs2 = 1'b0;
        for (int k = W_SLOT; k >= 0; k--) begin
            if (slot_match(r_slot[k], dec_rs1_i, dec_use_rs1_i))
                w_lu_rs1 = r_slot[k].is_load && (k < MEM_STAGES);
            if (slot_match(r_slot[k], dec_rs2_i, dec_use_rs2_i))
                w_lu_rs2 = r_slot[k].is_load && (k < MEM_STAGES);
        end
    end

    assign w_load_use  = dec_valid_i && (w_lu_rs1 || w_lu_rs2);
    assign w_issue     = dec_valid_i && !w_load_use && !redirect_e_i;
    assign w_stall_inc = !hold_i && !redirect_e_i && w_load_use;
    assign w_flush_inc = !hold_i && redirect_e_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot      <= '0;
            r_e_use_rs1 <= 1'b0;
            r_e_use_rs2 <= 1'b0;
        end else if (!hold_i) begin
            for (int k = W_SLOT; k >= 1; k--) begin
                r_slot[k] <= r_slot[k-1];
            end
            if (w_issue) begin
                r_slot[0]   <= '{valid: 1'b1, rd: SLOT_AW'(dec_rd_i),
                                 reg_write: dec_reg_write_i, is_load: dec_is_load_i};
                r_e_use_rs1 <= dec_use_rs1_i;
                r_e_use_rs2 <= dec_use_rs2_i;
            end else begin
                r_slot[0]   <= '0;
                r_e_use_rs1 <= 1'b0;
                r_e_use_rs2 <= 1'b0;
            end
        end
    end

    // Source addresses are only meaningful alongside their use flags, so they skip reset.
    always_ff @(posedge clk) begin
        if (!hold_i) begin
            r_e_rs1 <= dec_rs1_i;
            r_e_rs2 <= dec_rs2_i;
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (w_stall_inc),
        .o_count (w_stall_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc     (w_flush_inc),
        .o_count (w_flush_cnt)
    );

    always_comb begin
        stall_fd_o  = 1'b0;
        flush_d_o   = 1'b0;
        flush_e_o   = 1'b0;
        fwd_rs1_e_o = '0;
        fwd_rs2_e_o = '0;
        stall_cnt_o = '0;
        flush_cnt_o = '0;
        if (!rst) begin
            fwd_rs1_e_o = w_fwd_rs1;
            fwd_rs2_e_o = w_fwd_rs2;
            stall_cnt_o = w_stall_cnt;
            flush_cnt_o = w_flush_cnt;
            if (hold_i) begin
                stall_fd_o = 1'b1;
            end else if (redirect_e_i) begin
                flush_d_o = 1'b1;
                flush_e_o = 1'b1;
            end else if (w_load_use) begin
                stall_fd_o = 1'b1;
                flush_e_o  = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: two controllers (1 and 2 memory stages) driven in parallel and
// checked against an in-flight instruction list model.
module tb_hazard_ctrl;

    localparam int MS_A = 1;
    localparam int CW_A = 16;
    localparam int MS_B = 2;
    localparam int CW_B = 2;
    localparam int FW_A = $clog2(MS_A + 2);
    localparam int FW_B = $clog2(MS_B + 2);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hold_i = 1'b0;
    logic       dec_valid_i = 1'b0;
    logic [4:0] dec_rs1_i = '0;
    logic [4:0] dec_rs2_i = '0;
    logic       dec_use_rs1_i = 1'b0;
    logic       dec_use_rs2_i = 1'b0;
    logic [4:0] dec_rd_i = '0;
    logic       dec_reg_write_i = 1'b0;
    logic       dec_is_load_i = 1'b0;
    logic       redirect_e_i = 1'b0;

    logic            a_stall, a_fd, a_fe;
    logic [FW_A-1:0] a_f1, a_f2;
    logic [CW_A-1:0] a_sc, a_fc;
    logic            b_stall, b_fd, b_fe;
    logic [FW_B-1:0] b_f1, b_f2;
    logic [CW_B-1:0] b_sc, b_fc;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(5), .MEM_STAGES(MS_A), .CNT_WIDTH(CW_A)) dut_a (
        .clk(clk), .rst(rst), .hold_i(hold_i), .dec_valid_i(dec_valid_i),
        .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i),
        .dec_use_rs1_i(dec_use_rs1_i), .dec_use_rs2_i(dec_use_rs2_i),
        .dec_rd_i(dec_rd_i), .dec_reg_write_i(dec_reg_write_i),
        .dec_is_load_i(dec_is_load_i), .redirect_e_i(redirect_e_i),
        .stall_fd_o(a_stall), .flush_d_o(a_fd), .flush_e_o(a_fe),
        .fwd_rs1_e_o(a_f1), .fwd_rs2_e_o(a_f2),
        .stall_cnt_o(a_sc), .flush_cnt_o(a_fc)
    );

    hazard_ctrl #(.REG_AW(5), .MEM_STAGES(MS_B), .CNT_WIDTH(CW_B)) dut_b (
        .clk(clk), .rst(rst), .hold_i(hold_i), .dec_valid_i(dec_valid_i),
        .dec_rs1_i(dec_rs1_i), .dec_rs2_i(dec_rs2_i),
        .dec_use_rs1_i(dec_use_rs1_i), .dec_use_rs2_i(dec_use_rs2_i),
        .dec_rd_i(dec_rd_i), .dec_reg_write_i(dec_reg_write_i),
        .dec_is_load_i(dec_is_load_i), .redirect_e_i(redirect_e_i),
        .stall_fd_o(b_stall), .flush_d_o(b_fd), .flush_e_o(b_fe),
        .fwd_rs1_e_o(b_f1), .fwd_rs2_e_o(b_f2),
        .stall_cnt_o(b_sc), .flush_cnt_o(b_fc)
    );

    typedef struct {
        bit v; int rd; bit wr; bit ld; int rs1; int rs2; bit u1; bit u2;
    } ins_t;

    typedef struct {
        bit stall; bit fd; bit fe; int f1; int f2; int sc; int fc; bit lu;
    } exp_t;

    // Model: per controller, an in-flight list indexed by age (0 = E, last = W).
    ins_t mq[2][$];
    int   msv[2];
    int   cwv[2];
    int   scm[2];
    int   fcm[2];
    exp_t expq[2][$];

    int  nchk = 0;
    int  nerr = 0;
    bit  last_stall_a = 1'b0;

    task automatic chk(input string name, input int act, input int want);
        nchk++;
        if (act != want) begin
            nerr++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, want);
        end
    endtask

    function automatic void reset_model(input int id);
        ins_t empty;
        empty = '{default: 0};
        mq[id].delete();
        for (int k = 0; k < msv[id] + 2; k++) mq[id].push_back(empty);
        scm[id] = 0;
        fcm[id] = 0;
    endfunction

    // Youngest in-flight instruction in ages lo..hi that writes register r, or -1.
    function automatic int producer(input int id, input int lo, input int hi,
                                    input int r, input bit u);
        for (int k = lo; k <= hi; k++) begin
            if (u && r != 0 && mq[id][k].v && mq[id][k].wr && mq[id][k].rd == r) return k;
        end
        return -1;
    endfunction

    function automatic exp_t predict(input int id);
        exp_t e;
        int   j;
        int   ms;
        ms = msv[id];
        e  = '{default: 0};
        if (rst) return e;
        j = producer(id, 1, ms + 1, mq[id][0].rs1, mq[id][0].u1);
        e.f1 = (j < 0) ? 0 : j;
        j = producer(id, 1, ms + 1, mq[id][0].rs2, mq[id][0].u2);
        e.f2 = (j < 0) ? 0 : j;
        if (dec_valid_i) begin
            j = producer(id, 0, ms, int'(dec_rs1_i), dec_use_rs1_i);
            if (j >= 0 && j < ms && mq[id][j].ld) e.lu = 1'b1;
            j = producer(id, 0, ms, int'(dec_rs2_i), dec_use_rs2_i);
            if (j >= 0 && j < ms && mq[id][j].ld) e.lu = 1'b1;
        end
        if (hold_i) begin
            e.stall = 1'b1;
        end else if (redirect_e_i) begin
            e.fd = 1'b1;
            e.fe = 1'b1;
        end else if (e.lu) begin
            e.stall = 1'b1;
            e.fe    = 1'b1;
        end
        e.sc = scm[id];
        e.fc = fcm[id];
        return e;
    endfunction

    function automatic void advance(input int id, input bit lu);
        ins_t nx;
        int   cmax;
        cmax = (1 << cwv[id]) - 1;
        nx   = '{default: 0};
        if (rst) begin
            reset_model(id);
        end else if (!hold_i) begin
            if (lu && !redirect_e_i && scm[id] < cmax) scm[id]++;
            if (redirect_e_i && fcm[id] < cmax) fcm[id]++;
            if (dec_valid_i && !lu && !redirect_e_i)
                nx = '{1'b1, int'(dec_rd_i), dec_reg_write_i, dec_is_load_i,
                       int'(dec_rs1_i), int'(dec_rs2_i), dec_use_rs1_i, dec_use_rs2_i};
            void'(mq[id].pop_back());
            mq[id].push_front(nx);
        end
    endfunction

    // Monitor: compares each cycle's outputs against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (expq[0].size() > 0) begin
            e = expq[0].pop_front();
            chk("A.stall_fd", int'(a_stall), int'(e.stall));
            chk("A.flush_d", int'(a_fd), int'(e.fd));
            chk("A.flush_e", int'(a_fe), int'(e.fe));
            chk("A.fwd_rs1", int'(a_f1), e.f1);
            chk("A.fwd_rs2", int'(a_f2), e.f2);
            chk("A.stall_cnt", int'(a_sc), e.sc);
            chk("A.flush_cnt", int'(a_fc), e.fc);
        end
        if (expq[1].size() > 0) begin
            e = expq[1].pop_front();
            chk("B.stall_fd", int'(b_stall), int'(e.stall));
            chk("B.flush_d", int'(b_fd), int'(e.fd));
            chk("B.flush_e", int'(b_fe), int'(e.fe));
            chk("B.fwd_rs1", int'(b_f1), e.f1);
            chk("B.fwd_rs2", int'(b_f2), e.f2);
            chk("B.stall_cnt", int'(b_sc), e.sc);
            chk("B.flush_cnt", int'(b_fc), e.fc);
        end
    end

    task automatic cyc(input bit r, input bit h, input bit redir);
        exp_t e0, e1;
        rst          = r;
        hold_i       = h;
        redirect_e_i = redir;
        e0 = predict(0);
        e1 = predict(1);
        expq[0].push_back(e0);
        expq[1].push_back(e1);
        last_stall_a = e0.stall;
        @(posedge clk);
        advance(0, e0.lu);
        advance(1, e1.lu);
        #1;
    endtask

    task automatic set_dec(input int rd, input int rs1, input int rs2, input bit u1,
                           input bit u2, input bit wr, input bit ld);
        dec_valid_i     = 1'b1;
        dec_rd_i        = 5'(rd);
        dec_rs1_i       = 5'(rs1);
        dec_rs2_i       = 5'(rs2);
        dec_use_rs1_i   = u1;
        dec_use_rs2_i   = u2;
        dec_reg_write_i = wr;
        dec_is_load_i   = ld;
    endtask

    // Presents an instruction in D until the single-memory-stage controller accepts it.
    task automatic issue(input int rd, input int rs1, input int rs2, input bit u1,
                         input bit u2, input bit wr, input bit ld);
        set_dec(rd, rs1, rs2, u1, u2, wr, ld);
        for (int n = 0; n < 8; n++) begin
            cyc(1'b0, 1'b0, 1'b0);
            if (!last_stall_a) return;
        end
        nchk++;
        nerr++;
        $display("FAIL issue_timeout at t=%0t: stall still %0d, expected 0", $time, a_stall);
    endtask

    task automatic bubbles(input int n);
        dec_valid_i = 1'b0;
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        msv[0] = MS_A; cwv[0] = CW_A;
        msv[1] = MS_B; cwv[1] = CW_B;
        reset_model(0);
        reset_model(1);
        @(posedge clk);
        #1;

        // Reset with a live decode and redirect: everything must read zero.
        set_dec(6, 2, 0, 1, 0, 1, 1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        bubbles(2);

        // ALU chain: forward from M1.
        issue(5, 1, 2, 1, 1, 1, 0);
        issue(7, 5, 1, 1, 1, 1, 0);
        bubbles(3);

        // Load-use.
        issue(6, 2, 0, 1, 0, 1, 1);
        issue(7, 6, 6, 1, 1, 1, 0);
        bubbles(4);

        // x0 never forwards; the youngest producer wins over an older load.
        issue(0, 1, 0, 1, 0, 1, 0);
        issue(8, 0, 0, 1, 1, 1, 0);
        bubbles(3);
        issue(6, 2, 0, 1, 0, 1, 1);
        issue(6, 1, 0, 1, 0, 1, 0);
        issue(9, 6, 0, 1, 0, 1, 0);
        bubbles(4);

        // Redirect arriving during a load-use stall.
        issue(6, 2, 0, 1, 0, 1, 1);
        set_dec(7, 6, 0, 1, 0, 1, 0);
        cyc(1'b0, 1'b0, 1'b1);
        bubbles(4);

        // Hold for three cycles with a dependent instruction waiting in D.
        issue(6, 2, 0, 1, 0, 1, 1);
        set_dec(7, 6, 6, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0);
        issue(7, 6, 6, 1, 1, 1, 0);
        bubbles(4);

        // Back-to-back load-use pairs push the narrow counter into saturation.
        for (int i = 0; i < 3; i++) begin
            issue(10 + i, 1, 0, 1, 0, 1, 1);
            issue(20 + i, 10 + i, 0, 1, 0, 1, 0);
        end
        bubbles(4);

        // Randomised traffic over a small register set.
        for (int i = 0; i < 1200; i++) begin
            set_dec($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
            dec_valid_i = ($urandom_range(0, 3) != 0);
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0));
        end
        bubbles(3);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", expq[0].size() + expq[1].size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
